// File: rtl/seq_detector_prog_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_prog_pkg
// Shared constants and helpers for the programmable serial pattern detector.
//   DEF_MAX_LEN / DEF_CNT_W : default pattern length limit and counter width
//   OVL_ON / OVL_OFF        : encodings of the overlap-mode configuration bit
//   clamp_len()             : limits a requested pattern length to MAX_LEN
// -----------------------------------------------------------------------------
package seq_detector_prog_pkg;

  localparam int unsigned DEF_MAX_LEN = 32'd8;
  localparam int unsigned DEF_CNT_W   = 32'd8;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Requested lengths beyond the history depth are treated as the full depth.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    int unsigned res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// -----------------------------------------------------------------------------
// seq_sat_counter
// Saturating up-counter used for the detector's match count.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the count
//   clr_i  : synchronous clear (lower priority than rst)
//   inc_i  : increment request; ignored once the count is all-ones
//   cnt_o  : registered count value
// -----------------------------------------------------------------------------
module seq_sat_counter #(
  parameter int unsigned W = 32'd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
// Programmable serial bit-pattern detector with registered (Moore) outputs.
// A pattern of 1..MAX_LEN bits is loaded at runtime; incoming qualified bits
// shift into a history register and are compared against the pattern.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   cfg_load_i     : latch cfg_pattern_i / cfg_len_i / cfg_overlap_i, clear history
//   cfg_pattern_i  : pattern, bit [len-1] arrives first, bit [0] last
//   cfg_len_i      : pattern length (0 disables, >MAX_LEN clamps)
//   cfg_overlap_i  : 1 = overlapping, 0 = non-overlapping detection
//   d_i, d_valid_i : serial data bit and its qualifier
//   match_o        : one-cycle pulse the cycle after the completing bit
//   match_count_o  : saturating number of matches since load/reset
//   armed_o        : a non-zero length is loaded
// -----------------------------------------------------------------------------
module seq_detector_prog
  import seq_detector_prog_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = 32'd4,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               d_i,
  input  logic               d_valid_i,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               armed_o
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic               overlap_q, overlap_d;
  logic               match_q,   match_d;
  logic               armed_q,   armed_d;

  logic [LEN_W-1:0]   cfg_len_clamped_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [MAX_LEN-1:0] shifted_s;
  logic [MAX_LEN-1:0] len_mask_s;
  logic               hit_s;

  assign cfg_len_clamped_s = LEN_W'(clamp_len(32'(cfg_len_i), MAX_LEN));

  // Mask selecting the low len_q history bits that take part in the compare.
  always_comb begin
    len_mask_s = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(len_q)) begin
        len_mask_s[i] = 1'b1;
      end else begin
        len_mask_s[i] = 1'b0;
      end
    end
  end

  // Candidate history/fill after accepting d_i, and the match decision on it.
  always_comb begin
    shifted_s = {hist_q[MAX_LEN-2:0], d_i};
    if (fill_q >= MAX_LEN_L) begin
      fill_inc_s = MAX_LEN_L;
    end else begin
      fill_inc_s = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    // Fill gates stale history: after a non-overlapping match the old bits
    // stay in hist_q but cannot match until len fresh bits have arrived.
    hit_s = armed_q
         && (fill_inc_s >= len_q)
         && (((shifted_s ^ pattern_q) & len_mask_s) == '0);
  end

  // Next-state: configuration load has priority over the datapath.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    len_d     = len_q;
    fill_d    = fill_q;
    overlap_d = overlap_q;
    armed_d   = armed_q;
    match_d   = 1'b0;
    if (cfg_load_i) begin
      pattern_d = cfg_pattern_i;
      len_d     = cfg_len_clamped_s;
      overlap_d = cfg_overlap_i;
      armed_d   = (cfg_len_clamped_s != '0);
      hist_d    = '0;
      fill_d    = '0;
      match_d   = 1'b0;
    end else if (d_valid_i && armed_q) begin
      hist_d  = shifted_s;
      match_d = hit_s;
      if (hit_s && (overlap_q == OVL_OFF)) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      hist_q    <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      armed_q   <= armed_d;
    end
  end

  // The counter steps on the same edge that raises match_q, so the count
  // already includes a match while its pulse is visible.
  seq_sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cfg_load_i),
    .inc_i (match_d),
    .cnt_o (match_count_o)
  );

  assign match_o = match_q;
  assign armed_o = armed_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       d = 1'b0;
  logic       d_valid = 1'b0;

  logic       match_o, armed_o, c2_match_o, c2_armed_o;
  logic [7:0] match_count_o;
  logic [1:0] c2_count_o;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  // behavioural model state
  logic       q[$];
  logic [7:0] m_pat = 8'd0;
  int         m_len = 0;
  bit         m_ovl = 1'b0;
  logic       exp_match = 1'b0;
  logic       exp_armed = 1'b0;
  int         exp_cnt8 = 0;
  int         exp_cnt2 = 0;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .d_i(d), .d_valid_i(d_valid),
    .match_o(match_o), .match_count_o(match_count_o), .armed_o(armed_o)
  );

  seq_detector_prog #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .d_i(d), .d_valid_i(d_valid),
    .match_o(c2_match_o), .match_count_o(c2_count_o), .armed_o(c2_armed_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the bits seen since the last load/reset/non-overlapping match,
  // newest last; a match is the last len bits spelling the pattern MSB-first.
  task automatic model_step();
    bit hit;
    started = 1'b1;
    if (rst) begin
      q.delete(); m_pat = 8'd0; m_len = 0; m_ovl = 1'b0;
      exp_match = 1'b0; exp_armed = 1'b0; exp_cnt8 = 0; exp_cnt2 = 0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
      m_ovl = cfg_overlap;
      q.delete();
      exp_match = 1'b0; exp_armed = (m_len != 0); exp_cnt8 = 0; exp_cnt2 = 0;
    end else if (d_valid && m_len != 0) begin
      q.push_back(d);
      if (q.size() > 8) void'(q.pop_front());
      hit = (q.size() >= m_len);
      for (int i = 0; i < m_len; i++)
        if (hit && q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
      exp_match = hit;
      if (hit) begin
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt2 < 3) exp_cnt2++;
        if (!m_ovl) q.delete();
      end
    end else begin
      exp_match = 1'b0;
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      check("match", match_o, exp_match);
      check("match_count", match_count_o, exp_cnt8);
      check("armed", armed_o, exp_armed);
      check("c2_match", c2_match_o, exp_match);
      check("c2_count", c2_count_o, exp_cnt2);
      check("c2_armed", c2_armed_o, exp_armed);
    end
  end

  task automatic tick(output logic m);
    @(posedge clk);
    model_step();
    @(negedge clk);
    m = match_o;
  endtask

  task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic dv, input logic dd);
    logic m;
    rst = 1'b0; cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    d = dd; d_valid = dv;
    tick(m);
    cfg_load = 1'b0; d_valid = 1'b0;
  endtask

  task automatic send(input logic dd, input logic dv, output logic m);
    rst = 1'b0; cfg_load = 1'b0; d = dd; d_valid = dv;
    tick(m);
    d_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n, output logic [7:0] rec);
    logic m;
    rec = 8'd0;
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b1, m);
      rec = {rec[6:0], m};
    end
  endtask

  initial begin
    logic m;
    logic [7:0] rec;
    logic [5:0] rec6;
    int any;

    // 1. reset with toggling data
    rst = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = i[0];
      tick(m);
      check("rst_match", match_o, 0);
      check("rst_count", match_count_o, 0);
      check("rst_armed", armed_o, 0);
    end
    rst = 1'b0; d_valid = 1'b0;

    // 2. overlapping 1010
    do_load(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0);
    check("ovl_armed", armed_o, 1);
    send_bits(8'b10101010, 8, rec);
    check("ovl_pulses", rec, 8'b00010101);
    check("ovl_count", match_count_o, 3);

    // 3. non-overlapping 1010
    do_load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0);
    send_bits(8'b10101010, 8, rec);
    check("novl_pulses", rec, 8'b00010001);
    check("novl_count", match_count_o, 2);

    // 4. gapped input, pattern 110
    do_load(8'b110, 4'd3, 1'b1, 1'b0, 1'b0);
    rec6 = 6'd0;
    send(1'b1, 1'b1, m); rec6 = {rec6[4:0], m};
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, m); rec6 = {rec6[4:0], m};
    end
    send(1'b1, 1'b1, m); rec6 = {rec6[4:0], m};
    send(1'b0, 1'b1, m); rec6 = {rec6[4:0], m};
    check("gap_pulses", rec6, 6'b000001);

    // 5a. zero length disables
    do_load(8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    any = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(0, 1)), 1'b1, m);
      if (m) any++;
    end
    check("len0_armed", armed_o, 0);
    check("len0_matches", any, 0);
    check("len0_count", match_count_o, 0);

    // 5b. length 15 clamps to 8
    do_load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
    send_bits(8'hA5, 8, rec);
    check("clamp_pulses", rec, 8'b00000001);
    check("clamp_count", match_count_o, 1);

    // 5c. bit coincident with cfg_load is dropped
    do_load(8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b1, m);
    check("coinc_first", m, 0);
    send(1'b1, 1'b1, m);
    check("coinc_second", m, 1);

    // 6a. saturation
    do_load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, m);
    check("sat_cnt8", match_count_o, 5);
    check("sat_cnt2", c2_count_o, 3);

    // 6b. reset / reload abort a partial sequence
    do_load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send_bits(8'b101, 3, rec);
    rst = 1'b1; tick(m); rst = 1'b0;
    send(1'b1, 1'b1, m);
    check("abort_rst", m, 0);
    do_load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send_bits(8'b101, 3, rec);
    do_load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, m);
    check("abort_load", m, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_load    = ($urandom_range(0, 39) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      d           = 1'($urandom_range(0, 1));
      d_valid     = ($urandom_range(0, 3) != 0);
      tick(m);
    end
    rst = 1'b0; cfg_load = 1'b0; d_valid = 1'b0;
    tick(m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial bit-pattern detector with a Moore-style registered output. It generalises the fixed 4-bit, hard-wired pattern FSM detector to a runtime-loadable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, input qualification, and a saturating match counter. It sits on a serial data path behind a bit deserialiser or GPIO synchroniser and feeds status to a controller.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, 4, width of the pattern-length field; must hold MAX_LEN.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
cfg_load  input  1  latches cfg_pattern, cfg_len and cfg_overlap; clears detection history.
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit expected, bit [0] the last.
cfg_len  input  LEN_W  pattern length in bits.
cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
d  input  1  serial data bit.
d_valid  input  1  d is sampled only on edges where this is 1.
match  output  1  1-cycle pulse on a completed match.
match_count  output  CNT_W  number of matches, saturating.
armed  output  1  1 when a valid length is loaded, so detection is enabled.

Behaviour:
- Reset (rst=1 at a clock edge) sets the following; rst has priority over everything:
  - match=0, match_count=0, armed=0.
  - History and fill count cleared.
  - Stored pattern=0, length=0, overlap=0.
- Configuration:
  - On cfg_load=1, the registers take cfg_* on that edge. History, fill count and match_count clear, and match=0.
  - If cfg_load and d_valid are high together, cfg_load wins and that d bit is discarded.
  - A length of 0 disables detection: armed=0 and match is never asserted.
  - A length above MAX_LEN clamps to MAX_LEN.
  - armed=1 from the cycle after a load with a length of 1 or more.
- Datapath on an edge with d_valid=1, armed=1 and no cfg_load:
  - History shifts left with d entering at bit 0 (hist <= {hist[MAX_LEN-2:0], d}).
  - Fill count increments, saturating at MAX_LEN.
- Match condition, evaluated on the post-shift history: fill is at least len AND hist[len-1:0] == pattern[len-1:0]. Bits above len are ignored (masked compare).
- match is registered. It is high for exactly the one cycle after the edge that sampled the final pattern bit, so latency is one clock from the last bit sampled.
- On an edge with d_valid=0:
  - History and fill are held.
  - match is 0 for the following cycle. It is not stretched.
- Overlap mode (overlap=1): fill is kept after a match, so suffix bits may start the next match.
- Non-overlap mode (overlap=0):
  - On the matching edge, fill is set to 0. History bits remain but are ignored until len fresh bits have arrived.
  - Equivalent FSM: return to the idle state on the completing bit.
- match_count increments by 1 on each match and holds at 2^CNT_W-1 once saturated.
- Reset mid-stream discards any partial sequence. Mid-stream cfg_load behaves the same way.
- No combinational path from any input to any output.

Decomposition:
- Shared package or include: constants DEF_MAX_LEN=8 and DEF_CNT_W=8; localparams OVL_ON=1 and OVL_OFF=0; the length clamp as a function.
- One sub-module, seq_sat_counter: parameter W, inputs clk, rst, clr, inc; output cnt; saturating. It is instantiated for match_count.
- History and compare logic stay inline.

Test Plan:
1. Reset then idle: rst high for 2 cycles with d toggling -> match=0, match_count=0, armed=0 throughout.
2. Overlap, pattern 1010, len=4, overlap=1; stream 1,0,1,0,1,0,1,0 with d_valid=1 -> match pulses after bits 4, 6 and 8; match_count=3.
3. Non-overlap, same stream with overlap=0 -> match pulses after bits 4 and 8 only; match_count=2.
4. Gapped input: pattern 110, len=3; bits 1, (d_valid=0 for 3 cycles), 1, 0 -> one match, one cycle after the final 0 is sampled. No pulse during the gaps.
5. Boundaries:
   - len=0 load -> armed=0, no matches on any stream.
   - len=15 with MAX_LEN=8 -> clamps to 8; pattern 0xA5 matched after 8 bits.
   - cfg_load coincident with d_valid -> that bit is dropped.
6. Saturation and abort:
   - CNT_W=2, 5 matches -> match_count holds at 3.
   - rst asserted after 3 of 4 pattern bits, then the remaining bit -> no match.
